// File: rtl/fta_io_target64.sv
// fta_io_target64: generic 64-bit FTA responder for low-speed I/O devices.
// It decodes an address window and holds a byte-writable register file. Register 0
// is a read-only ID constant. Each accepted request gets exactly one registered
// response after WAIT_STATES extra cycles.
//
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-low reset
//   req    - request from the bridge (cyc, stb, we, sel, padr, dat, cid, tid, bte, cti, cmd)
//   resp   - response to the bridge (ack, err, rty, next, stall, dat, cid, tid, adr, pri)

package fta_io_target64_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] padr;
        logic [63:0] dat;
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [1:0]  bte;
        logic [2:0]  cti;
        logic [4:0]  cmd;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        next;
        logic        stall;
        logic [63:0] dat;
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [3:0]  pri;
    } fta_cmd_response64_t;

endpackage

module fta_io_target64
    import fta_io_target64_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'hFEE00000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFFF000,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [63:0] ID          = 64'h0000_0000_1054_4754
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  fta_cmd_request64_t  req,
    output fta_cmd_response64_t resp
);

    localparam int unsigned IdxW = $clog2(NREGS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    fta_cmd_response64_t resp_q, resp_d;

    logic                we_q;
    logic [7:0]          sel_q;
    logic [63:0]         dat_q;
    logic [3:0]          cid_q;
    logic [7:0]          tid_q;
    logic [31:0]         padr_q;

    // Register 0 is the ID constant, so only 1..NREGS-1 are stored.
    logic [63:0]         regs_q [1:NREGS-1];

    logic                hit;
    logic                lat_en;
    logic                wr_en;
    logic                is_err;
    logic [IdxW-1:0]     idx;
    logic [63:0]         rd_data;

    // Burst/command qualifiers are ignored: every beat is a single access.
    logic                unused_req;
    assign unused_req = ^{req.bte, req.cti, req.cmd};

    assign hit    = req.cyc & req.stb & ((req.padr & ADDR_MASK) == ADDR_BASE);
    assign idx    = padr_q[3 +: IdxW];
    assign is_err = (sel_q == 8'h00) || (we_q && (idx == '0));
    assign wr_en  = (state_q == StResp) && we_q && !is_err;
    assign resp   = resp_q;

    always_comb begin
        rd_data = ID;
        for (int i = 1; i < NREGS; i++) begin
            if (idx == IdxW'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_en     = 1'b0;
        resp_d     = resp_q;
        resp_d.ack = 1'b0;
        resp_d.err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    lat_en       = 1'b1;
                    resp_d.stall = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                resp_d.stall = 1'b0;
                resp_d.ack   = !is_err;
                resp_d.err   = is_err;
                resp_d.rty   = 1'b0;
                resp_d.next  = 1'b0;
                resp_d.pri   = '0;
                resp_d.dat   = (is_err || we_q) ? 64'h0 : rd_data;
                resp_d.cid   = cid_q;
                resp_d.tid   = tid_q;
                resp_d.adr   = padr_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            resp_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            cid_q   <= '0;
            tid_q   <= '0;
            padr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            if (lat_en) begin
                we_q   <= req.we;
                sel_q  <= req.sel;
                dat_q  <= req.dat;
                cid_q  <= req.cid;
                tid_q  <= req.tid;
                padr_q <= req.padr;
            end
        end
    end

    // Write lands on the same edge that registers the ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NREGS; i++) begin
                for (int b = 0; b < 8; b++) begin
                    if ((idx == IdxW'(i)) && sel_q[b]) begin
                        regs_q[i][8*b +: 8] <= dat_q[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: doc/fta_io_target64.md
Name: fta_io_target64

Overview:
Generic 64-bit FTA bus responder for low-speed I/O devices on the narrow side of the 128-to-64 I/O bridge. It decodes an address window and holds a small byte-writable 64-bit register file. It returns one registered response per accepted request after a programmable number of wait states. It is the template responder that I/O cores instantiate behind the bridge's channel response inputs.

Parameters:
ADDR_BASE, 32'hFEE00000, window base; hit when (padr & ADDR_MASK) == ADDR_BASE
ADDR_MASK, 32'hFFFFF000, window decode mask
NREGS, 16, number of 64-bit registers (power of 2, 2..256); index = padr[3 +: $clog2(NREGS)]
WAIT_STATES, 2, extra cycles between accept and response (0..15)
ID, 64'h0000_0000_1054_4754, read-only contents of register 0

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
req  in  fta_cmd_request64_t  request from bridge: cyc, stb, we, sel[7:0], padr[31:0], dat[63:0], cid, tid, bte, cti, cmd
resp  out  fta_cmd_response64_t  response to bridge: ack, err, rty, next, stall, dat[63:0], cid, tid, adr, pri

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_i low). All state clears immediately and no clock is required.
- Reset values: every resp field = 0, including stall. State = IDLE. Registers 1..NREGS-1 = 0. Register 0 is the constant ID and is not stored.
- Reset asserted mid-transaction aborts it: no ack is issued and any pending write is discarded.
- Hit = req.cyc & req.stb & ((req.padr & ADDR_MASK) == ADDR_BASE).
- Non-hit requests are ignored: no response, no stall, no state change.
- FSM states:
  - IDLE: stall = 0. A hit sampled at edge E0 is accepted. Latch we, sel, dat, cid, tid, padr, and set stall = 1 at E0. If WAIT_STATES = 0, go to RESP. Otherwise go to WAIT with cnt = WAIT_STATES - 1.
  - WAIT: cnt decrements each edge. At cnt = 0, go to RESP.
  - RESP: at edge E0+WAIT_STATES+1, drive the response registers and clear stall. Go to IDLE.
- Response timing: ack (or err) is high for exactly one cycle, registered at edge E0+WAIT_STATES+1 and cleared at the next edge.
- Response fields: cid, tid and adr equal the latched values. pri = 0, rty = 0, next = 0.
- Back-to-back requests: a hit presented during the ack cycle is accepted at the following edge. Maximum throughput is one request per WAIT_STATES+2 cycles.
- Stalled requests: a request presented while stall = 1 is not accepted. The initiator holds it until stall = 0.
- Read: dat = register[index], returned as the full 64 bits regardless of sel. ack = 1, err = 0.
- Write: for each byte lane b with sel[b] = 1, register[index][8b+7:8b] = dat byte b. The update occurs at the same edge that asserts ack. resp.dat = 0.
- Error cases (err = 1, ack = 0, dat = 0, no register change):
  - write to index 0;
  - sel == 8'h00 on any access.
- A read in the response cycle cannot see a same-cycle write: requests are strictly serialized by the FSM.
- bte, cti and cmd are ignored (single-beat only). Burst requests are treated as independent single accesses.

Test Plan:
- Reset/ID: hold rst_i low, then release; read padr 32'hFEE00000. Required: stall high at the accept edge, ack high exactly 3 cycles after accept (WAIT_STATES = 2), dat = 64'h0000_0000_1054_4754, cid/tid echoed.
- Byte write: write padr 32'hFEE00008, sel 8'h0F, dat 64'h1122334455667788, then read back. Required: write acked, read dat = 64'h0000000055667788.
- Error paths: write to 32'hFEE00000, and read 32'hFEE00010 with sel 8'h00. Required: err = 1, ack = 0 for one cycle each; a subsequent read of register 0 still returns ID.
- Miss and stall: request 32'hFEF00000 → no response and stall stays 0. Hit request held while stall = 1 → accepted only once, exactly one ack.
- Back-to-back with WAIT_STATES = 0: two reads with the second presented during the first ack. Required: acks two cycles apart with correct cid/tid ordering.
- Async reset mid-op: drop rst_i between clock edges during WAIT. Required: resp is all zeros immediately, no ack follows, and the written register is unchanged.
